range_sweep: RTL and testbench
==============================

// Module: range_sweep
// PURPOSE
//  Producer counterpart to the range/offset checkers. Given a base and an
//  offset (same low/delta convention as offset_check), emits every value in
//  [low, low+delta] in ascending order, one per accepted transfer, over a
//  valid/ready stream. Used to walk brick/paddle extents for drawing and
//  collision sweeps in the Breakout datapath.
// PARAMETERS
//  WIDTH  10  bit width of low, delta and the emitted value
// PORTS
//  clock      in   1      system clock; all state changes on posedge
//  reset      in   1      asynchronous, active-high; returns block to IDLE
//  start      in   1      request a sweep; sampled only in IDLE
//  low        in   WIDTH  first value of sweep; captured when start accepted
//  delta      in   WIDTH  offset to last value; captured when start accepted
//  abort      in   1      synchronous cancel of a sweep in progress
//  val        out  WIDTH  current value; meaningful only when val_valid=1
//  val_valid  out  1      val is offered to consumer
//  val_ready  in   1      consumer accepts val this cycle
//  val_last   out  1      asserted with val_valid on the final value
//  busy       out  1      1 in RUN and DONE, 0 in IDLE
//  done       out  1      one-cycle pulse after the last value is accepted
// BEHAVIOUR
//  Reset: state=IDLE; val=0, val_valid=0, val_last=0, busy=0, done=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at an edge captures low and delta; end computed as
//   low+delta in WIDTH+1 bits, clamped to 2^WIDTH-1 on overflow
//   (no wrap-around). Next cycle: RUN, val=low, val_valid=1.
//   Start-to-first-valid latency: 1 cycle.
//  RUN: val_valid=1 every cycle; val_last = (val==end).
//   val_valid && val_ready && !val_last: val <= val+1 next cycle.
//   val_valid && !val_ready: val and val_last held stable (no drop).
//   val_valid && val_ready && val_last: next cycle DONE, val_valid=0.
//  DONE: done=1, busy=1, val_valid=0 for exactly one cycle; then IDLE.
//   Back-to-back: a start may be sampled in the IDLE cycle after DONE;
//   minimum gap between sweeps is therefore 2 cycles after the last
//   transfer.
//  start while in RUN or DONE: ignored; no effect on the sweep in progress.
//  delta=0: single transfer; val_last=1 on the first offered value.
//  abort=1 in RUN: next cycle IDLE, val_valid=0, no done pulse. abort
//   wins over a same-cycle accepted last value (that transfer still
//   counts at the consumer, but done is suppressed). abort in IDLE/DONE:
//   ignored.
//  Reset mid-sweep: immediate return to IDLE, all outputs to reset
//   values, no done.
//  low/delta changes after capture have no effect until the next start.
//  val never exceeds end; no combinational path from val_ready to val.
// TESTING
//  T1 WIDTH=10, low=5, delta=3, ready=1: val 5,6,7,8 on 4 consecutive
//   cycles, val_last only with 8, done=1 on the next cycle, then busy=0.
//  T2 Same sweep, ready low 2 cycles while val=6: val stays 6, valid
//   held, then 7,8; exactly 4 transfers, one done pulse.
//  T3 low=1020, delta=10: val 1020..1023 then last; no wrap to 0.
//  T4 delta=0, low=42: single transfer val=42 with val_last=1, then done.
//  T5 start re-asserted during RUN with new low=100: ignored, original
//   sweep completes. abort at val=7 of T1: IDLE next cycle, no done.
//  T6 Assert reset asynchronously mid-sweep: val_valid, busy and done drop
//   immediately; a fresh start after release runs a full sweep.

Source files
------------

// File: rtl/range_sweep.sv
// -----------------------------------------------------------------------------
// range_sweep
//   Streams every value in [low, low+delta] in ascending order over a
//   valid/ready interface, one value per accepted transfer. The end value is
//   computed at full width and clamped to the largest representable value,
//   so a sweep near the top of the range stops there instead of wrapping.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high; returns to IDLE with outputs cleared
//   start      request a sweep (sampled only in IDLE)
//   low        first value of the sweep (captured with start)
//   delta      offset from low to the last value (captured with start)
//   abort      cancel a sweep in progress (RUN only), no done pulse
//   val        current value, meaningful while val_valid=1
//   val_valid  val is offered to the consumer
//   val_ready  consumer accepts val this cycle
//   val_last   marks the final value of the sweep
//   busy       high in RUN and DONE
//   done       one-cycle pulse after the final value has been accepted
// -----------------------------------------------------------------------------
module range_sweep #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] delta,
    input  logic             abort,
    output logic [WIDTH-1:0] val,
    output logic             val_valid,
    input  logic             val_ready,
    output logic             val_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] val_reg;
    logic [WIDTH-1:0] end_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             busy_reg;
    logic             done_reg;

    // End of sweep: add with a carry bit and saturate on overflow.
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] end_next;
    logic [WIDTH-1:0] val_inc;

    assign sum_wide = {1'b0, low} + {1'b0, delta};
    assign end_next = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
    assign val_inc  = val_reg + WIDTH'(1);

    // val_last is registered alongside val so the consumer sees a stable
    // flag and there is no path from val_ready through the comparator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            val_reg   <= '0;
            end_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        val_reg   <= low;
                        end_reg   <= end_next;
                        valid_reg <= 1'b1;
                        last_reg  <= (low == end_next);
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort beats a same-cycle final transfer: no done.
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (val_ready) begin
                        if (last_reg) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            val_reg  <= val_inc;
                            last_reg <= (val_inc == end_reg);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign val       = val_reg;
    assign val_valid = valid_reg;
    assign val_last  = last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_range_sweep.sv
// -----------------------------------------------------------------------------
// tb_range_sweep
//   Table-driven sweeps checked through an expected-value queue, plus
//   hand-written sequences for abort and asynchronous reset mid-sweep.
// -----------------------------------------------------------------------------
module tb_range_sweep;

    localparam int WIDTH = 10;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] delta;
    logic             abort;
    logic [WIDTH-1:0] val;
    logic             val_valid;
    logic             val_ready;
    logic             val_last;
    logic             busy;
    logic             done;

    range_sweep #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .low       (low),
        .delta     (delta),
        .abort     (abort),
        .val       (val),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .val_last  (val_last),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int v;
        int last;
    } exp_t;

    // mode: 0 ready always, 1 random ready, 2 stall twice at val=6,
    //       3 re-assert start with other operands during the run
    typedef struct {
        int low;
        int delta;
        int mode;
        int exp_n;
    } vec_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   n_xfer;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Account for a transfer with the inputs as currently driven, then
    // advance to 1 time unit past the next rising edge.
    task automatic tick();
        exp_t e;
        if (val_valid && val_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer actual=%0d required=none", val);
            end else begin
                e = exp_q.pop_front();
                chk("val", int'(val), e.v);
                chk("val_last", int'(val_last), e.last);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_sweep(input int lo, input int dl);
        int hi;
        exp_t e;
        hi = (lo + dl > MAXV) ? MAXV : lo + dl;
        for (int v = lo; v <= hi; v++) begin
            e.v    = v;
            e.last = (v == hi) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_sweep(input vec_t t);
        int cycles;
        int stalls;
        bit seen_done;
        n_xfer    = 0;
        stalls    = 0;
        seen_done = 0;
        cycles    = 0;
        exp_q.delete();
        push_sweep(t.low, t.delta);
        start     = 1'b1;
        low       = WIDTH'(t.low);
        delta     = WIDTH'(t.delta);
        val_ready = 1'b0;
        tick();
        start = 1'b0;
        // Later operand changes must not disturb the captured sweep.
        low   = WIDTH'(t.low + 37);
        delta = WIDTH'(t.delta + 5);
        chk("first_valid", int'(val_valid), 1);
        chk("first_val", int'(val), t.low);
        chk("busy_run", int'(busy), 1);
        while (!seen_done && cycles < 3000) begin
            case (t.mode)
                1: val_ready = ($urandom_range(3) != 0);
                2: begin
                    if (val == 6 && stalls < 2) begin
                        val_ready = 1'b0;
                        stalls++;
                    end else begin
                        val_ready = 1'b1;
                    end
                end
                3: begin
                    val_ready = 1'b1;
                    start     = 1'b1;
                    low       = WIDTH'(100);
                    delta     = WIDTH'(3);
                end
                default: val_ready = 1'b1;
            endcase
            tick();
            cycles++;
            if (done) seen_done = 1;
            if (t.mode == 2 && stalls > 0 && stalls <= 2 && !seen_done && val_ready == 1'b0) begin
                chk("stall_hold_val", int'(val), 6);
                chk("stall_hold_valid", int'(val_valid), 1);
            end
        end
        start = 1'b0;
        chk("done_seen", int'(seen_done), 1);
        chk("done_valid_low", int'(val_valid), 0);
        chk("done_busy", int'(busy), 1);
        chk("xfer_count", n_xfer, t.exp_n);
        chk("queue_empty", exp_q.size(), 0);
        if (t.mode == 0 || t.mode == 3) chk("burst_cycles", cycles, t.exp_n);
        val_ready = 1'b1;
        tick();
        chk("done_pulse_end", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        $display("sweep low=%0d delta=%0d mode=%0d xfers=%0d cycles=%0d",
                 t.low, t.delta, t.mode, n_xfer, cycles);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t t;
        checks    = 0;
        errors    = 0;
        n_xfer    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        low       = '0;
        delta     = '0;
        abort     = 1'b0;
        val_ready = 1'b0;

        vecs[0] = '{low: 5,    delta: 3,    mode: 0, exp_n: 4};    // T1
        vecs[1] = '{low: 5,    delta: 3,    mode: 2, exp_n: 4};    // T2
        vecs[2] = '{low: 1020, delta: 10,   mode: 0, exp_n: 4};    // T3
        vecs[3] = '{low: 42,   delta: 0,    mode: 0, exp_n: 1};    // T4
        vecs[4] = '{low: 5,    delta: 3,    mode: 3, exp_n: 4};    // T5 start ignored
        vecs[5] = '{low: 1023, delta: 5,    mode: 0, exp_n: 1};
        vecs[6] = '{low: 700,  delta: 400,  mode: 1, exp_n: 324};
        vecs[7] = '{low: 0,    delta: 1023, mode: 1, exp_n: 1024};

        #1;
        chk("rst_val", int'(val), 0);
        chk("rst_valid", int'(val_valid), 0);
        chk("rst_last", int'(val_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_sweep(vecs[i]);

        // T5 abort at val=7 with a same-cycle transfer: 7 counts, no done.
        exp_q.delete();
        push_sweep(5, 3);
        n_xfer    = 0;
        start     = 1'b1;
        low       = WIDTH'(5);
        delta     = WIDTH'(3);
        val_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && val != 7; k++) tick();
        chk("abort_at7", int'(val), 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", int'(val_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_xfers", n_xfer, 3);
        chk("abort_left", exp_q.size(), 1);
        tick();
        chk("abort_no_done", int'(done), 0);
        $display("abort sweep low=5 delta=3 xfers=%0d", n_xfer);

        // Abort with the final value accepted in the same cycle: done suppressed.
        exp_q.delete();
        push_sweep(42, 0);
        start = 1'b1;
        low   = WIDTH'(42);
        delta = WIDTH'(0);
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_last_done", int'(done), 0);
        chk("abort_last_busy", int'(busy), 0);
        chk("abort_last_q", exp_q.size(), 0);
        $display("abort on last value low=42");

        // T6 asynchronous reset mid-sweep.
        exp_q.delete();
        push_sweep(0, 20);
        start = 1'b1;
        low   = WIDTH'(0);
        delta = WIDTH'(20);
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", int'(val_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_val", int'(val), 0);
        chk("arst_last", int'(val_last), 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        chk("arst_stay_idle", int'(val_valid), 0);
        $display("reset mid-sweep");
        t = '{low: 3, delta: 2, mode: 0, exp_n: 3};
        run_sweep(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
